// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronizer, 3-sample majority vote,
// optional parity, 1 or 2 stop bits, break detection, atomic output update.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } state_t;

  state_t               state, state_next;
  logic                 sync1, sync2;
  logic [2:0]           hist;
  logic                 maj, fall;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [3:0]           bit_cnt, bit_next;
  logic [DATA_BITS-1:0] data_sh;
  logic                 par_bit, stop0, ferr_acc;
  logic                 shift_en, par_en, stop_en, done;
  logic                 sample;
  logic                 first_stop, ferr_now, perr_now, brk_now;

  assign maj    = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign fall   = ~sync2 & hist[0];
  assign sample = (cnt == LAST_CNT);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_cnt <= bit_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    bit_next   = bit_cnt;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        if (fall) state_next = S_START;
      end
      S_START: begin
        if (cnt == HALF_CNT) begin
          cnt_next   = '0;
          state_next = maj ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (sample) begin
          cnt_next = '0;
          shift_en = 1'b1;
          if (bit_cnt == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          cnt_next   = '0;
          par_en     = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          cnt_next = '0;
          stop_en  = 1'b1;
          if (bit_cnt == STOP_LAST) begin
            bit_next   = '0;
            done       = 1'b1;
            state_next = S_CLEANUP;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      S_CLEANUP: begin
        cnt_next = '0;
        if (maj) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        bit_next   = '0;
      end
    endcase
  end

  // Error flags are resolved from the final stop sample so they land with the strobe.
  always_comb begin
    first_stop = (bit_cnt == '0) ? maj : stop0;
    ferr_now   = ferr_acc | ~maj;
    brk_now    = ~(|data_sh) & ((PARITY == 0) | ~par_bit) & ~first_stop;
    perr_now   = 1'b0;
    if (PARITY == 1) perr_now = ~(^{data_sh, par_bit});
    else if (PARITY == 2) perr_now = ^{data_sh, par_bit};
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      hist         <= '1;
      data_sh      <= '0;
      par_bit      <= 1'b0;
      stop0        <= 1'b0;
      ferr_acc     <= 1'b0;
      o_RX_DV      <= 1'b0;
      o_RX_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      sync1   <= i_RX_Serial;
      sync2   <= sync1;
      hist    <= {hist[1:0], sync2};
      o_RX_DV <= done;
      if (shift_en) data_sh <= {maj, data_sh[DATA_BITS-1:1]};
      if (par_en) par_bit <= maj;
      if (state == S_IDLE) begin
        ferr_acc <= 1'b0;
      end else if (stop_en) begin
        ferr_acc <= ferr_now;
        if (bit_cnt == '0) stop0 <= maj;
      end
      if (done) begin
        o_RX_Byte    <= data_sh;
        o_Parity_Err <= perr_now;
        o_Frame_Err  <= ferr_now;
        o_Break      <= brk_now;
      end
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning system clocks per serial bit (legal range 8..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..9).
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame (legal values 1 or 2).
REQ-005 SHALL have port i_Clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port i_Rst_L, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port i_RX_Serial, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port o_RX_DV, output, 1 bit: one-cycle frame-complete strobe.
REQ-009 SHALL have port o_RX_Byte, output, DATA_BITS bits: received data, LSB first on the line.
REQ-010 SHALL have port o_Parity_Err, output, 1 bit: parity mismatch on the last frame.
REQ-011 SHALL have port o_Frame_Err, output, 1 bit: a stop bit sampled low on the last frame.
REQ-012 SHALL have port o_Break, output, 1 bit: break detected on the last frame.

Function
REQ-013 SHALL pass i_RX_Serial through a 2-flop synchronizer, then a 3-bit history shift register; every bit decision is the majority of the 3 history bits.
REQ-014 SHALL use states IDLE, START, DATA, PARITY, STOP, CLEANUP, encoded in 3 bits; undefined codes go to IDLE.
REQ-015 SHALL have IDLE leave to START on a synchronized high-to-low transition; the bit counter and clock counter clear.
REQ-016 SHALL place sample points at H + k*CLKS_PER_BIT clocks after START entry, where H = (CLKS_PER_BIT-1)/2 (integer) and k = 0 is the start bit.
REQ-017 SHALL, at the START sample point, return to IDLE with no strobe and no output change if the majority is 1 (glitch reject); otherwise go to DATA.
REQ-018 SHALL, in DATA, store each majority sample into o_RX_Byte bit position 0..DATA_BITS-1 in order; after DATA_BITS samples, go to PARITY if PARITY != 0, else to STOP.
REQ-019 SHALL, in PARITY, take one sample; a parity error exists if the XOR of the data bits and the parity bit equals 0 for odd parity or 1 for even parity.
REQ-020 SHALL, in STOP, take STOP_BITS samples; a frame error exists if any stop sample is 0.
REQ-021 SHALL, on the clock after the final stop sample, pulse o_RX_DV high for exactly 1 cycle and update o_Parity_Err, o_Frame_Err, o_Break and o_RX_Byte together.
REQ-022 SHALL hold o_RX_Byte and all error flags stable until the next o_RX_DV.
REQ-023 SHALL assert o_Break when all data bits are 0, the parity bit (if enabled) is 0, and the first stop sample is 0; o_Frame_Err is also 1 in that case.
REQ-024 SHALL have CLEANUP wait until the synchronized line (majority) is 1, then return to IDLE, so a held-low line never produces a second frame.
REQ-025 SHALL size the clock counter as $clog2(CLKS_PER_BIT) bits and never let it wrap within a bit period.
REQ-026 SHALL not leave o_RX_Byte partially updated: data shifts into an internal register and copies to the output only with o_RX_DV.

Reset
REQ-027 SHALL, while i_Rst_L = 0, force the state to IDLE, all counters to 0, synchronizer and history registers to all-ones, and o_RX_DV, o_RX_Byte, o_Parity_Err, o_Frame_Err and o_Break to 0, immediately and regardless of i_Clk.
REQ-028 SHALL abandon a frame when reset asserts mid-frame, with no strobe; after release, the next valid start edge is received normally.

Verification (CLKS_PER_BIT=16 unless noted)
REQ-029 SHALL cover 8N1, byte 0xA5, stop high: expect one o_RX_DV, o_RX_Byte=0xA5, all error flags 0.
REQ-030 SHALL cover PARITY=2, data 0x03, parity bit 1: expect o_RX_DV, o_RX_Byte=0x03, o_Parity_Err=1; with the parity bit set to 0 instead, expect o_Parity_Err=0.
REQ-031 SHALL cover a 4-clock low pulse on an idle line: expect no o_RX_DV and outputs unchanged.
REQ-032 SHALL cover byte 0x5A with the stop bit driven low: expect o_RX_DV, o_Frame_Err=1, o_Break=0.
REQ-033 SHALL cover the line held low for 30 bit times: expect exactly one o_RX_DV with o_RX_Byte=0x00, o_Break=1 and o_Frame_Err=1; then, after the line returns high, a frame with byte 0x11 decodes correctly.
REQ-034 SHALL cover i_Rst_L pulsed low during data bit 4 of a frame: expect no o_RX_DV and outputs 0; then the next frame, byte 0xC3, decodes with all error flags 0.
